// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encodings, owner IDs,
// default limits and the fixed-priority arbitration decision.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    localparam int DEF_TIMEOUT      = 255;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef struct packed {
        logic valid;
        logic owner;
    } arb_t;

    // LS wins unless IF is waiting and has already lost STARVE_LIMIT times in a row.
    function automatic arb_t arbitrate(input logic if_req, input logic ls_req,
                                       input logic if_starved);
        arb_t res;
        res.valid = if_req | ls_req;
        res.owner = (ls_req && !(if_req && if_starved)) ? OWN_LS : OWN_IF;
        return res;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// Response watchdog: counts cycles since the grant and flags when TIMEOUT is reached.
module bus_timeout_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt;

    // The grant cycle itself is cycle 0, so the first busy cycle already reads 1
    // and the counter always equals the number of cycles elapsed since grant.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= 8'd1;
        end else if (enable && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the IF and LS requesters onto a single memory port, one outstanding
// transaction at a time, with LS priority, IF anti-starvation and a response timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,

    input  logic            if_req,
    input  logic            if_we,
    input  logic [AW-1:0]   if_addr,
    input  logic [DW-1:0]   if_wdata,
    input  logic [DW/8-1:0] if_wstrb,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    output logic            if_err,

    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    input  logic [DW/8-1:0] ls_wstrb,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,
    output logic            ls_err,

    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int             SCW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    logic [1:0]     state, state_nxt;
    logic           owner;
    logic [SCW-1:0] starve_cnt;

    arb_t arb;
    logic grant, busy, completion, expired, timed_out, resp;

    assign arb        = arbitrate(if_req, ls_req, starve_cnt == STARVE_MAX);
    assign grant      = (state == ST_IDLE) && arb.valid;
    assign busy       = (state == ST_ISSUE) || (state == ST_WAIT);
    assign completion = (state == ST_WAIT) && mem_rvalid;
    assign timed_out  = busy && expired && !completion;
    assign resp       = completion || timed_out;

    assign if_gnt    = grant && (arb.owner == OWN_IF);
    assign ls_gnt    = grant && (arb.owner == OWN_LS);
    assign if_rvalid = resp && (owner == OWN_IF);
    assign ls_rvalid = resp && (owner == OWN_LS);
    assign if_err    = timed_out && (owner == OWN_IF);
    assign ls_err    = timed_out && (owner == OWN_LS);
    assign if_rdata  = (completion && owner == OWN_IF) ? mem_rdata : '0;
    assign ls_rdata  = (completion && owner == OWN_LS) ? mem_rdata : '0;

    // Decoded from state so an async reset drops the request immediately.
    assign mem_req = (state == ST_ISSUE);

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (timed_out)      state_nxt = ST_IDLE;
                else if (mem_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (resp) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            starve_cnt <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner <= arb.owner;
                if (arb.owner == OWN_LS) begin
                    mem_we    <= ls_we;
                    mem_addr  <= ls_addr;
                    mem_wdata <= ls_wdata;
                    mem_wstrb <= ls_wstrb;
                    if (if_req && starve_cnt != STARVE_MAX)
                        starve_cnt <= starve_cnt + SCW'(1);
                end else begin
                    mem_we     <= if_we;
                    mem_addr   <= if_addr;
                    mem_wdata  <= if_wdata;
                    mem_wstrb  <= if_wstrb;
                    starve_cnt <= '0;
                end
            end
        end
    end

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .clear   (grant),
        .enable  (busy),
        .expired (expired)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: a vector table for the basic
// transactions plus hand-written stall, starvation, timeout and reset sequences.
module tb_mem_bus_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        if_req, if_we, ls_req, ls_we;
    logic [31:0] if_addr, if_wdata, ls_addr, ls_wdata;
    logic [3:0]  if_wstrb, ls_wstrb;
    logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    mem_bus_arbiter dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .if_req     (if_req),
        .if_we      (if_we),
        .if_addr    (if_addr),
        .if_wdata   (if_wdata),
        .if_wstrb   (if_wstrb),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_wstrb   (ls_wstrb),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .ls_err     (ls_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        string       nm;
        logic        ir, lr, lwe;
        logic [31:0] ia, la, lwd;
        logic        rdy, rv;
        logic [31:0] rd;
        logic        x_ig, x_lg, x_mr, x_mwe;
        logic [31:0] x_ma, x_mwd;
        logic        x_irv, x_lrv;
        logic [31:0] x_rd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 units later,
    // well before the next rising edge.
    task automatic cyc();
        @(negedge sys_clk);
    endtask

    task automatic idle_inputs();
        if_req = 0; ls_req = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    // One transaction with zero-wait memory: arbitration, issue, response.
    task automatic do_txn(input logic ir, input logic lr, input logic exp_ls,
                          input logic [31:0] rd, input string nm);
        cyc();
        if_req = ir; ls_req = lr; mem_ready = 0; mem_rvalid = 0;
        #2;
        check({nm, "_if_gnt"}, 32'(if_gnt), 32'(!exp_ls));
        check({nm, "_ls_gnt"}, 32'(ls_gnt), 32'(exp_ls));
        cyc();
        if_req = ir && exp_ls; ls_req = lr && !exp_ls; mem_ready = 1;
        #2;
        check({nm, "_mem_req"}, 32'(mem_req), 32'd1);
        check({nm, "_mem_addr"}, mem_addr, exp_ls ? ls_addr : if_addr);
        cyc();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = rd;
        #2;
        check({nm, "_if_rvalid"}, 32'(if_rvalid), 32'(!exp_ls));
        check({nm, "_ls_rvalid"}, 32'(ls_rvalid), 32'(exp_ls));
        check({nm, "_rdata"}, exp_ls ? ls_rdata : if_rdata, rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;

        //            nm             ir lr lwe ia          la          lwd           rdy rv rd
        //                           ig lg mr mwe ma        mwd           irv lrv rd
        vecs[0] = '{"if_rd_arb",     1, 0, 0, 32'h100, 32'h0,   32'h0,        0, 0, 32'h0,
                                     1, 0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0};
        vecs[1] = '{"if_rd_issue",   0, 0, 0, 32'h100, 32'h0,   32'h0,        1, 0, 32'h0,
                                     0, 0, 1, 0, 32'h100, 32'h0,        0, 0, 32'h0};
        vecs[2] = '{"if_rd_resp",    0, 0, 0, 32'h100, 32'h0,   32'h0,        0, 1, 32'hDEADBEEF,
                                     0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 32'hDEADBEEF};
        vecs[3] = '{"both_arb",      1, 1, 1, 32'h300, 32'h200, 32'h12345678, 0, 0, 32'h0,
                                     0, 1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0};
        vecs[4] = '{"ls_wr_issue",   1, 0, 1, 32'h300, 32'h200, 32'h12345678, 1, 0, 32'h0,
                                     0, 0, 1, 1, 32'h200, 32'h12345678, 0, 0, 32'h0};
        vecs[5] = '{"ls_wr_ack",     1, 0, 1, 32'h300, 32'h200, 32'h12345678, 0, 1, 32'h0,
                                     0, 0, 0, 0, 32'h0,   32'h0,        0, 1, 32'h0};
        vecs[6] = '{"if_after_ls",   1, 0, 0, 32'h300, 32'h200, 32'h0,        0, 0, 32'h0,
                                     1, 0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0};
        vecs[7] = '{"if2_issue",     0, 0, 0, 32'h300, 32'h200, 32'h0,        1, 0, 32'h0,
                                     0, 0, 1, 0, 32'h300, 32'h0,        0, 0, 32'h0};
        vecs[8] = '{"if2_resp",      0, 0, 0, 32'h300, 32'h200, 32'h0,        0, 1, 32'h0BADF00D,
                                     0, 0, 0, 0, 32'h0,   32'h0,        1, 0, 32'h0BADF00D};
        vecs[9] = '{"stray_idle",    0, 0, 0, 32'h300, 32'h200, 32'h0,        0, 1, 32'hFFFFFFFF,
                                     0, 0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0};

        sys_rst_n = 0;
        if_we = 0; if_wdata = '0; if_wstrb = 4'h0; if_addr = '0;
        ls_we = 0; ls_wdata = '0; ls_wstrb = 4'hF; ls_addr = '0;
        idle_inputs();
        #2;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        check("rst_rvalid", 32'({if_rvalid, ls_rvalid, if_err, ls_err}), 32'h0);
        check("rst_rdata", if_rdata | ls_rdata, 32'h0);
        cyc();
        sys_rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            cyc();
            if_req = vecs[i].ir; ls_req = vecs[i].lr; ls_we = vecs[i].lwe;
            if_addr = vecs[i].ia; ls_addr = vecs[i].la; ls_wdata = vecs[i].lwd;
            mem_ready = vecs[i].rdy; mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rd;
            #2;
            check({vecs[i].nm, "_if_gnt"}, 32'(if_gnt), 32'(vecs[i].x_ig));
            check({vecs[i].nm, "_ls_gnt"}, 32'(ls_gnt), 32'(vecs[i].x_lg));
            check({vecs[i].nm, "_mem_req"}, 32'(mem_req), 32'(vecs[i].x_mr));
            check({vecs[i].nm, "_if_rvalid"}, 32'(if_rvalid), 32'(vecs[i].x_irv));
            check({vecs[i].nm, "_ls_rvalid"}, 32'(ls_rvalid), 32'(vecs[i].x_lrv));
            check({vecs[i].nm, "_err"}, 32'({if_err, ls_err}), 32'h0);
            check({vecs[i].nm, "_if_rdata"}, if_rdata, vecs[i].x_irv ? vecs[i].x_rd : 32'h0);
            check({vecs[i].nm, "_ls_rdata"}, ls_rdata, vecs[i].x_lrv ? vecs[i].x_rd : 32'h0);
            if (vecs[i].x_mr) begin
                check({vecs[i].nm, "_mem_we"}, 32'(mem_we), 32'(vecs[i].x_mwe));
                check({vecs[i].nm, "_mem_addr"}, mem_addr, vecs[i].x_ma);
                check({vecs[i].nm, "_mem_wdata"}, mem_wdata, vecs[i].x_mwd);
                check({vecs[i].nm, "_mem_wstrb"}, 32'(mem_wstrb), vecs[i].x_mwe ? 32'hF : 32'h0);
            end
        end

        // mem_ready held low for 3 cycles, with a stray mem_rvalid while issuing.
        cyc();
        idle_inputs();
        ls_req = 1; ls_we = 1; ls_addr = 32'h500; ls_wdata = 32'hCAFEF00D;
        #2;
        check("stall_ls_gnt", 32'(ls_gnt), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            ls_req = 0; ls_addr = 32'h0; ls_wdata = 32'h0;
            mem_rvalid = (c == 2);
            mem_rdata = 32'h11111111;
            #2;
            check("stall_mem_req", 32'(mem_req), 32'd1);
            check("stall_mem_addr", mem_addr, 32'h500);
            check("stall_mem_wdata", mem_wdata, 32'hCAFEF00D);
            check("stall_no_rvalid", 32'({if_rvalid, ls_rvalid}), 32'h0);
        end
        cyc();
        mem_rvalid = 0; mem_ready = 1;
        #2;
        check("stall_ready_mem_req", 32'(mem_req), 32'd1);
        cyc();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0;
        #2;
        check("stall_ls_rvalid", 32'(ls_rvalid), 32'd1);
        check("stall_ls_err", 32'(ls_err), 32'd0);

        // IF held while LS keeps requesting: LS wins 4 times, IF the 5th, then LS again.
        ls_we = 0; if_addr = 32'h700; ls_addr = 32'h800;
        for (int k = 1; k <= 5; k++)
            do_txn(1'b1, 1'b1, k < 5, 32'h1000 + 32'(k), $sformatf("starve%0d", k));
        do_txn(1'b1, 1'b1, 1'b1, 32'h2000, "starve_reset");

        // Memory accepts but never responds: error response 255 cycles after grant.
        cyc();
        idle_inputs();
        if_req = 1; if_addr = 32'h600;
        #2;
        check("tmo_if_gnt", 32'(if_gnt), 32'd1);
        seen = 0;
        for (int c = 1; c <= 300; c++) begin
            cyc();
            if_req = 0; mem_ready = (c == 1);
            #2;
            if (if_rvalid || ls_rvalid) begin
                seen = c;
                break;
            end
        end
        check("tmo_cycle", 32'(seen), 32'd255);
        check("tmo_if_rvalid", 32'(if_rvalid), 32'd1);
        check("tmo_if_err", 32'(if_err), 32'd1);
        check("tmo_if_rdata", if_rdata, 32'h0);
        check("tmo_ls_rvalid", 32'(ls_rvalid), 32'd0);
        cyc();
        mem_rvalid = 1; mem_rdata = 32'hABCDABCD;
        #2;
        check("tmo_mem_req_low", 32'(mem_req), 32'd0);
        check("tmo_stray_rvalid", 32'({if_rvalid, ls_rvalid, if_err}), 32'h0);
        mem_rvalid = 0;
        do_txn(1'b1, 1'b0, 1'b0, 32'h3333, "post_tmo");

        // Async reset during WAIT_RESP while a response is on the bus.
        cyc();
        idle_inputs();
        if_req = 1; if_addr = 32'h900;
        #2;
        check("rstw_if_gnt", 32'(if_gnt), 32'd1);
        cyc();
        if_req = 0; mem_ready = 1;
        #2;
        check("rstw_mem_req", 32'(mem_req), 32'd1);
        cyc();
        mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h44444444;
        #1;
        check("rstw_pre_rvalid", 32'(if_rvalid), 32'd1);
        sys_rst_n = 0;
        #1;
        check("rstw_async_rvalid", 32'({if_rvalid, ls_rvalid}), 32'h0);
        check("rstw_async_mem_req", 32'(mem_req), 32'd0);
        check("rstw_async_mem_addr", mem_addr, 32'h0);
        cyc();
        sys_rst_n = 1;
        #2;
        check("rstw_stray_rvalid", 32'({if_rvalid, ls_rvalid}), 32'h0);
        check("rstw_idle_mem_req", 32'(mem_req), 32'd0);
        mem_rvalid = 0;
        do_txn(1'b1, 1'b0, 1'b0, 32'h5555AAAA, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
